// File: rtl/vdma_baseaddr_ring.sv
// Frame-ring controller for one VDMA writer/reader pair: the reader always takes the
// newest completed buffer and the writer never targets the buffer being read.
module vdma_baseaddr_ring #(
    parameter int unsigned    NBUF       = 3,
    parameter int unsigned    PW         = 3,
    parameter int unsigned    AW         = 32,
    parameter logic [AW-1:0]  BASE_ADDR  = 32'h1000_0000,
    parameter logic [AW-1:0]  FRAME_SIZE = 32'h0080_0000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_vs_i,
    input  logic          rd_vs_i,
    input  logic          cnt_clr_i,
    output logic [PW-1:0] wr_point_o,
    output logic [PW-1:0] rd_point_o,
    output logic [AW-1:0] wr_baseaddr_o,
    output logic [AW-1:0] rd_baseaddr_o,
    output logic [15:0]   drop_cnt_o,
    output logic [15:0]   rpt_cnt_o
);

    localparam logic [PW-1:0] LAST_IDX = PW'(NBUF - 1);
    localparam logic [15:0]   CNT_MAX  = 16'hFFFF;

    logic          wr_vs_q, rd_vs_q, sof_block_q;
    logic          wr_active_q, rd_started_q, done_valid_q;
    logic [PW-1:0] wr_point_q, rd_point_q, last_done_q;
    logic [AW-1:0] wr_baseaddr_q, rd_baseaddr_q;
    logic [15:0]   drop_cnt_q, rpt_cnt_q;

    logic          wr_sof, rd_sof, wr_complete, done_valid_pre, rd_take;
    logic          wr_active_d, rd_started_d, done_valid_d;
    logic [PW-1:0] wr_point_d, rd_point_d, last_done_d;
    logic [AW-1:0] wr_baseaddr_d, rd_baseaddr_d;
    logic [15:0]   drop_cnt_d, rpt_cnt_d;
    logic [PW-1:0] cand;
    logic          found;

    // The first edge after reset only re-learns the vs levels, so a vs held high
    // through reset release must fall and rise again before it counts as an SOF.
    assign wr_sof = wr_vs_i & ~wr_vs_q & ~sof_block_q;
    assign rd_sof = rd_vs_i & ~rd_vs_q & ~sof_block_q;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        wr_complete    = wr_sof & wr_active_q;
        wr_active_d    = wr_active_q | wr_sof;
        last_done_d    = wr_complete ? wr_point_q : last_done_q;
        done_valid_pre = done_valid_q | wr_complete;
        rd_take        = rd_sof & done_valid_pre;
        rd_point_d     = rd_take ? last_done_d : rd_point_q;
        done_valid_d   = done_valid_pre & ~rd_take;
        rd_started_d   = rd_started_q | rd_take;

        // NOTE: blocking assignments here model a sequential scan within one cycle.
        wr_point_d = wr_point_q;
        cand       = wr_point_q;
        found      = 1'b0;
        if (wr_complete) begin
            for (int k = 1; k < int'(NBUF); k++) begin
                cand = (cand == LAST_IDX) ? '0 : cand + PW'(1);
                if (!found && cand != rd_point_d && cand != last_done_d) begin
                    wr_point_d = cand;
                    found      = 1'b1;
                end
            end
        end

        wr_baseaddr_d = BASE_ADDR + AW'(wr_point_d) * FRAME_SIZE;
        rd_baseaddr_d = BASE_ADDR + AW'(rd_point_d) * FRAME_SIZE;

        drop_cnt_d = drop_cnt_q;
        if (cnt_clr_i)
            drop_cnt_d = '0;
        else if (wr_complete && done_valid_q && drop_cnt_q != CNT_MAX)
            drop_cnt_d = drop_cnt_q + 16'd1;

        rpt_cnt_d = rpt_cnt_q;
        if (cnt_clr_i)
            rpt_cnt_d = '0;
        else if (rd_sof && !done_valid_pre && rd_started_q && rpt_cnt_q != CNT_MAX)
            rpt_cnt_d = rpt_cnt_q + 16'd1;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_vs_q       <= 1'b0;
            rd_vs_q       <= 1'b0;
            sof_block_q   <= 1'b1;
            wr_active_q   <= 1'b0;
            rd_started_q  <= 1'b0;
            done_valid_q  <= 1'b0;
            wr_point_q    <= '0;
            rd_point_q    <= LAST_IDX;
            last_done_q   <= '0;
            wr_baseaddr_q <= BASE_ADDR;
            rd_baseaddr_q <= BASE_ADDR + AW'(NBUF - 1) * FRAME_SIZE;
            drop_cnt_q    <= '0;
            rpt_cnt_q     <= '0;
        end else begin
            wr_vs_q       <= wr_vs_i;
            rd_vs_q       <= rd_vs_i;
            sof_block_q   <= 1'b0;
            wr_active_q   <= wr_active_d;
            rd_started_q  <= rd_started_d;
            done_valid_q  <= done_valid_d;
            wr_point_q    <= wr_point_d;
            rd_point_q    <= rd_point_d;
            last_done_q   <= last_done_d;
            wr_baseaddr_q <= wr_baseaddr_d;
            rd_baseaddr_q <= rd_baseaddr_d;
            drop_cnt_q    <= drop_cnt_d;
            rpt_cnt_q     <= rpt_cnt_d;
        end
    end

    assign wr_point_o    = wr_point_q;
    assign rd_point_o    = rd_point_q;
    assign wr_baseaddr_o = wr_baseaddr_q;
    assign rd_baseaddr_o = rd_baseaddr_q;
    assign drop_cnt_o    = drop_cnt_q;
    assign rpt_cnt_o     = rpt_cnt_q;

endmodule

// File: tb/tb_vdma_baseaddr_ring.sv
// Bench for vdma_baseaddr_ring: a 3-buffer and an 8-buffer instance share stimulus and
// are compared each cycle against a frame-level reference model.
module tb_vdma_baseaddr_ring;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, wr_vs, rd_vs, cnt_clr;
    logic [2:0]  wp3, rp3, wp8, rp8;
    logic [31:0] wa3, ra3, wa8, ra8;
    logic [15:0] dc3, rc3, dc8, rc8;

    vdma_baseaddr_ring #(.NBUF(3), .PW(3)) dut (
        .clk_i(clk), .rst_i(rst), .wr_vs_i(wr_vs), .rd_vs_i(rd_vs), .cnt_clr_i(cnt_clr),
        .wr_point_o(wp3), .rd_point_o(rp3), .wr_baseaddr_o(wa3), .rd_baseaddr_o(ra3),
        .drop_cnt_o(dc3), .rpt_cnt_o(rc3)
    );

    vdma_baseaddr_ring #(.NBUF(8), .PW(3)) dut8 (
        .clk_i(clk), .rst_i(rst), .wr_vs_i(wr_vs), .rd_vs_i(rd_vs), .cnt_clr_i(cnt_clr),
        .wr_point_o(wp8), .rd_point_o(rp8), .wr_baseaddr_o(wa8), .rd_baseaddr_o(ra8),
        .drop_cnt_o(dc8), .rpt_cnt_o(rc8)
    );

    typedef struct {
        bit active, started, dvalid;
        int wp, rp, last, drop, rpt;
    } mstate_t;

    mstate_t m3, m8;
    bit      pw, pr;
    int      total = 0;
    int      bad   = 0;

    function automatic mstate_t mreset(input int nbuf);
        mstate_t s;
        s.active = 0; s.started = 0; s.dvalid = 0;
        s.wp = 0; s.rp = nbuf - 1; s.last = 0; s.drop = 0; s.rpt = 0;
        return s;
    endfunction

    // One clock of the frame-level rules: writer completion first, then reader pick,
    // then the writer's next buffer chosen around the reader's new buffer.
    function automatic mstate_t mstep(input mstate_t s, input int nbuf,
                                      input bit ws, input bit rs, input bit clr);
        mstate_t n = s;
        bit inc_d = 0, inc_r = 0, got = 0;
        if (ws) begin
            if (!s.active) n.active = 1;
            else begin
                inc_d = s.dvalid;
                n.last = s.wp;
                n.dvalid = 1;
            end
        end
        if (rs) begin
            if (n.dvalid) begin
                n.rp = n.last; n.dvalid = 0; n.started = 1;
            end else if (s.started) inc_r = 1;
        end
        if (ws && s.active) begin
            for (int k = 1; k < nbuf; k++) begin
                int c = (s.wp + k) % nbuf;
                if (!got && c != n.rp && c != n.last) begin
                    n.wp = c; got = 1;
                end
            end
        end
        if (clr) begin n.drop = 0; n.rpt = 0; end
        else begin
            if (inc_d && n.drop < 65535) n.drop++;
            if (inc_r && n.rpt < 65535) n.rpt++;
        end
        return n;
    endfunction

    function automatic logic [31:0] addr(input int p);
        return 32'h1000_0000 + 32'(p) * 32'h0080_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("n3_wr_point", 32'(wp3), 32'(m3.wp));
        check("n3_rd_point", 32'(rp3), 32'(m3.rp));
        check("n3_wr_base",  wa3, addr(m3.wp));
        check("n3_rd_base",  ra3, addr(m3.rp));
        check("n3_drop",     32'(dc3), 32'(m3.drop));
        check("n3_rpt",      32'(rc3), 32'(m3.rpt));
        check("n8_wr_point", 32'(wp8), 32'(m8.wp));
        check("n8_rd_point", 32'(rp8), 32'(m8.rp));
        check("n8_wr_base",  wa8, addr(m8.wp));
        check("n8_rd_base",  ra8, addr(m8.rp));
        check("n8_drop",     32'(dc8), 32'(m8.drop));
        check("n8_rpt",      32'(rc8), 32'(m8.rpt));
        check("n8_wr_ne_rd", 32'(wp8 != rp8), 32'd1);
    endtask

    task automatic cyc(input bit w, input bit r, input bit c);
        bit ws, rs;
        @(negedge clk);
        wr_vs = w; rd_vs = r; cnt_clr = c;
        ws = w & ~pw;
        rs = r & ~pr;
        pw = w; pr = r;
        m3 = mstep(m3, 3, ws, rs, c);
        m8 = mstep(m8, 8, ws, rs, c);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic sof(input bit w, input bit r);
        cyc(w, r, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input bit w, input bit r);
        @(negedge clk);
        rst = 1'b1; wr_vs = w; rd_vs = r; cnt_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        pw = w; pr = r;
        m3 = mreset(3);
        m8 = mreset(8);
        check_all();
    endtask

    initial begin
        rst = 1'b1; wr_vs = 1'b0; rd_vs = 1'b0; cnt_clr = 1'b0;

        // Reset values.
        do_reset(1'b0, 1'b0);
        check("rst_wr_point", 32'(wp3), 32'd0);
        check("rst_rd_point", 32'(rp3), 32'd2);
        check("rst_wr_base",  wa3, 32'h1000_0000);
        check("rst_rd_base",  ra3, 32'h1100_0000);
        check("rst_cnts",     {dc3, rc3}, 32'd0);
        check("rst8_rd_base", ra8, 32'h1380_0000);

        // Equal rate.
        sof(1, 0); check("eq1_wr", 32'(wp3), 32'd0);
        sof(1, 0); check("eq2_wr", 32'(wp3), 32'd1); check("eq2_rd", 32'(rp3), 32'd2);
        sof(0, 1); check("eq3_rd", 32'(rp3), 32'd0);
        sof(1, 0); check("eq4_wr", 32'(wp3), 32'd2);
        sof(0, 1); check("eq5_rd", 32'(rp3), 32'd1);
        sof(1, 0); check("eq6_wr", 32'(wp3), 32'd0);
        check("eq_cnts", {dc3, rc3}, 32'd0);

        // Fast writer.
        do_reset(1'b0, 1'b0);
        repeat (3) sof(1, 0);
        check("fast_wr",   32'(wp3), 32'd0);
        check("fast_drop", 32'(dc3), 32'd1);
        sof(0, 1);
        check("fast_rd",      32'(rp3), 32'd1);
        check("fast_rd_base", ra3, 32'h1080_0000);

        // Simultaneous SOFs from wr=1, last_done=0 valid, rd=2.
        do_reset(1'b0, 1'b0);
        sof(1, 0); sof(1, 0);
        sof(1, 1);
        check("sim_rd",   32'(rp3), 32'd1);
        check("sim_wr",   32'(wp3), 32'd2);
        check("sim_drop", 32'(dc3), 32'd1);

        // Slow writer and reader SOF with nothing completed yet.
        do_reset(1'b0, 1'b0);
        sof(0, 1);
        check("early_rpt", 32'(rc3), 32'd0);
        sof(1, 0); sof(1, 0); sof(0, 1);
        sof(0, 1); sof(0, 1);
        check("slow_rd",  32'(rp3), 32'd0);
        check("slow_rpt", 32'(rc3), 32'd2);

        // vs held high through reset release is not an SOF.
        do_reset(1'b1, 1'b0);
        cyc(1, 0, 0); cyc(0, 0, 0);
        sof(1, 0);
        check("held_first_wr", 32'(wp3), 32'd0);
        sof(1, 0);
        check("held_second_wr", 32'(wp3), 32'd1);

        // Drop counter saturation, then clear winning over a same-cycle drop.
        do_reset(1'b0, 1'b0);
        sof(1, 0); sof(1, 0);
        @(negedge clk);
        force dut.drop_cnt_q = 16'hFFFD;
        #1;
        release dut.drop_cnt_q;
        m3.drop = 16'hFFFD;
        repeat (3) sof(1, 0);
        check("sat_drop", 32'(dc3), 32'h0000_FFFF);
        cyc(1, 0, 1);
        check("clr_drop", 32'(dc3), 32'd0);
        cyc(0, 0, 0);

        // Randomised traffic on both ring sizes.
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 600; i++)
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 40) == 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
